// File: rtl/nm_sequencer.sv
// nm_sequencer -- move sequencer for the board-game engine.
// Runs one check scan per direction through the line validator, then one
// flip scan for every direction that reported a capturable line, and
// finishes with a move-valid / board-write / done pulse.
// Ports:
//   clock, reset (async active-low)      -- clocking
//   enable                               -- start a new move (ignored while busy)
//   s_done, dir_status_in                -- validator handshake and result
//   ld_data_p_o, ld_e_addr_o             -- datapath load strobes (LOAD state)
//   step_o, ld_o, start_vali, flip_o     -- validator control
//   dir_mask_o                           -- per-direction check results
//   busy_o, mv_valid_o, write_to_mem_o, done_o -- status back to the controller
module nm_sequencer #(
  parameter int BOARD_W  = 10,
  parameter int NUM_DIRS = 8,
  parameter int STEP_W   = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       s_done,
  input  logic                       dir_status_in,
  output logic                       ld_data_p_o,
  output logic                       ld_e_addr_o,
  output logic signed [STEP_W-1:0]   step_o,
  output logic                       ld_o,
  output logic                       start_vali,
  output logic                       flip_o,
  output logic [NUM_DIRS-1:0]        dir_mask_o,
  output logic                       busy_o,
  output logic                       mv_valid_o,
  output logic                       write_to_mem_o,
  output logic                       done_o
);

  localparam int DW = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    V_START = 3'd2,
    V_WAIT  = 3'd3,
    EVAL    = 3'd4,
    F_START = 3'd5,
    F_WAIT  = 3'd6,
    FINAL   = 3'd7
  } state_t;

  state_t              state_r;
  logic [DW-1:0]       d_r;
  logic [NUM_DIRS-1:0] mask_r;

  logic [DW:0]         next_lo_s;   // {found, index} of lowest set mask bit
  logic [DW:0]         next_hi_s;   // {found, index} of next set bit above d_r
  logic                d_last_s;

  // Direction index to signed address step on the padded board.
  function automatic logic signed [STEP_W-1:0] dir_step(input logic [DW-1:0] d);
    int v;
    v = 32'sd0;
    case (int'(d))
      32'sd0:  v = -BOARD_W;
      32'sd1:  v = BOARD_W;
      32'sd2:  v = -32'sd1;
      32'sd3:  v = 32'sd1;
      32'sd4:  v = -BOARD_W - 32'sd1;
      32'sd5:  v = -BOARD_W + 32'sd1;
      32'sd6:  v = BOARD_W - 32'sd1;
      32'sd7:  v = BOARD_W + 32'sd1;
      default: v = 32'sd0;
    endcase
    return STEP_W'(v);
  endfunction

  // Lowest set bit of mask at or above 'from'; MSB of result flags a hit.
  function automatic logic [DW:0] next_bit(input logic [NUM_DIRS-1:0] mask, input int from);
    logic [DW:0] r;
    r = '0;
    // Scan downwards so the lowest qualifying bit is the last one written.
    for (int i = NUM_DIRS - 1; i >= 0; i--) begin
      if (i >= from && mask[i]) begin
        r = {1'b1, DW'(i)};
      end
    end
    return r;
  endfunction

  assign next_lo_s = next_bit(mask_r, 32'sd0);
  assign next_hi_s = next_bit(mask_r, int'(d_r) + 32'sd1);
  assign d_last_s  = (d_r == DW'(NUM_DIRS - 1));

  // Sequencer state, direction index and captured direction mask.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      d_r     <= '0;
      mask_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (enable) state_r <= LOAD;
        end
        LOAD: begin
          mask_r  <= '0;
          d_r     <= '0;
          state_r <= V_START;
        end
        V_START: state_r <= V_WAIT;
        V_WAIT: begin
          if (s_done) begin
            mask_r[d_r] <= dir_status_in;
            if (d_last_s) begin
              state_r <= EVAL;
            end else begin
              d_r     <= d_r + DW'(1);
              state_r <= V_START;
            end
          end
        end
        EVAL: begin
          if (next_lo_s[DW]) begin
            d_r     <= next_lo_s[DW-1:0];
            state_r <= F_START;
          end else begin
            state_r <= FINAL;
          end
        end
        F_START: state_r <= F_WAIT;
        F_WAIT: begin
          if (s_done) begin
            if (next_hi_s[DW]) begin
              d_r     <= next_hi_s[DW-1:0];
              state_r <= F_START;
            end else begin
              state_r <= FINAL;
            end
          end
        end
        FINAL:   state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Moore output decode from the state, index and mask registers.
  always_comb begin
    ld_data_p_o    = 1'b0;
    ld_e_addr_o    = 1'b0;
    step_o         = '0;
    ld_o           = 1'b0;
    start_vali     = 1'b0;
    flip_o         = 1'b0;
    mv_valid_o     = 1'b0;
    write_to_mem_o = 1'b0;
    done_o         = 1'b0;
    busy_o         = (state_r != IDLE);
    dir_mask_o     = mask_r;
    case (state_r)
      LOAD: begin
        ld_data_p_o = 1'b1;
        ld_e_addr_o = 1'b1;
      end
      V_START: begin
        ld_o       = 1'b1;
        start_vali = 1'b1;
        step_o     = dir_step(d_r);
      end
      V_WAIT: step_o = dir_step(d_r);
      F_START: begin
        ld_o       = 1'b1;
        start_vali = 1'b1;
        flip_o     = 1'b1;
        step_o     = dir_step(d_r);
      end
      F_WAIT: begin
        flip_o = 1'b1;
        step_o = dir_step(d_r);
      end
      FINAL: begin
        done_o         = 1'b1;
        mv_valid_o     = |mask_r;
        write_to_mem_o = |mask_r;
      end
      default: begin
        done_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_nm_sequencer.sv
module tb_nm_sequencer;

  logic clock = 1'b0;
  logic reset;
  logic enable, s_done, dir_status, sel_b;

  always #5 clock = ~clock;

  // DUT A: 8 directions
  logic a_ld_data, a_ld_e, a_ld, a_start, a_flip, a_busy, a_mv, a_wr, a_done;
  logic signed [7:0] a_step;
  logic [7:0] a_mask;
  // DUT B: 4 directions
  logic b_ld_data, b_ld_e, b_ld, b_start, b_flip, b_busy, b_mv, b_wr, b_done;
  logic signed [7:0] b_step;
  logic [3:0] b_mask;

  logic a_en, a_sd, a_ds, b_en, b_sd, b_ds;
  assign a_en = sel_b ? 1'b0 : enable;
  assign a_sd = sel_b ? 1'b0 : s_done;
  assign a_ds = sel_b ? 1'b0 : dir_status;
  assign b_en = sel_b ? enable : 1'b0;
  assign b_sd = sel_b ? s_done : 1'b0;
  assign b_ds = sel_b ? dir_status : 1'b0;

  nm_sequencer #(.BOARD_W(10), .NUM_DIRS(8), .STEP_W(8)) dut_a (
    .clock(clock), .reset(reset), .enable(a_en), .s_done(a_sd), .dir_status_in(a_ds),
    .ld_data_p_o(a_ld_data), .ld_e_addr_o(a_ld_e), .step_o(a_step), .ld_o(a_ld),
    .start_vali(a_start), .flip_o(a_flip), .dir_mask_o(a_mask), .busy_o(a_busy),
    .mv_valid_o(a_mv), .write_to_mem_o(a_wr), .done_o(a_done));

  nm_sequencer #(.BOARD_W(10), .NUM_DIRS(4), .STEP_W(8)) dut_b (
    .clock(clock), .reset(reset), .enable(b_en), .s_done(b_sd), .dir_status_in(b_ds),
    .ld_data_p_o(b_ld_data), .ld_e_addr_o(b_ld_e), .step_o(b_step), .ld_o(b_ld),
    .start_vali(b_start), .flip_o(b_flip), .dir_mask_o(b_mask), .busy_o(b_busy),
    .mv_valid_o(b_mv), .write_to_mem_o(b_wr), .done_o(b_done));

  // Selected-DUT view
  logic s_ld_data, s_ld_e, s_ld, s_start, s_flip, s_busy, s_mv, s_wr, s_done_o;
  logic [7:0] s_step, s_mask;
  assign s_ld_data = sel_b ? b_ld_data : a_ld_data;
  assign s_ld_e    = sel_b ? b_ld_e    : a_ld_e;
  assign s_ld      = sel_b ? b_ld      : a_ld;
  assign s_start   = sel_b ? b_start   : a_start;
  assign s_flip    = sel_b ? b_flip    : a_flip;
  assign s_busy    = sel_b ? b_busy    : a_busy;
  assign s_mv      = sel_b ? b_mv      : a_mv;
  assign s_wr      = sel_b ? b_wr      : a_wr;
  assign s_done_o  = sel_b ? b_done    : a_done;
  assign s_step    = sel_b ? b_step    : a_step;
  assign s_mask    = sel_b ? {4'b0000, b_mask} : a_mask;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries: {ld_o, flip_o, step_o}
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];
  logic [9:0] e, o;
  bit done_seen, rst_hit;
  logic obs_mv, obs_wr;
  logic [7:0] obs_mask;
  int ld_pulses;
  logic [24:0] rst_outs;

  int chk_steps[8] = '{-10, 10, -1, 1, -11, -9, 9, 11};

  task automatic push_checks(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b1, 1'b0, 8'(chk_steps[i])});
  endtask

  task automatic push_flip(input int step);
    exp_q.push_back({1'b1, 1'b1, 8'(step)});
  endtask

  // Drives one move: enable pulse, validator responses 3 cycles after each
  // start, records every scan start and the final status.
  task automatic run_seq(input logic [7:0] valid_set, input int ndirs, input bit glitch_en,
                         input bit stray_eval, input bit rst_fwait);
    int cnt, chk_idx;
    bit cur_flip, last_resp, stray;
    obs_q.delete();
    done_seen = 0; rst_hit = 0; ld_pulses = 0;
    obs_mv = 1'b0; obs_wr = 1'b0; obs_mask = 8'h00;
    cnt = 0; chk_idx = 0; cur_flip = 0; last_resp = 0;
    @(negedge clock);
    enable = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clock);
      enable = 1'b0; s_done = 1'b0; dir_status = 1'b0;
      stray = last_resp; last_resp = 0;
      if (rst_fwait && s_flip && !s_start && s_busy) begin
        reset = 1'b0;
        #1;
        rst_outs = {s_ld_data, s_ld_e, s_step, s_ld, s_start, s_flip, s_mask,
                    s_busy, s_mv, s_wr, s_done_o};
        rst_hit = 1;
        break;
      end
      if (s_done_o) begin
        done_seen = 1; obs_mv = s_mv; obs_wr = s_wr; obs_mask = s_mask;
        break;
      end
      if (s_ld_data && s_ld_e) ld_pulses++;
      if (stray_eval && stray) begin
        s_done = 1'b1; dir_status = 1'b1;
      end
      if (cnt > 0) begin
        cnt--;
        if (glitch_en && !cur_flip && cnt == 1) enable = 1'b1;
        if (cnt == 0) begin
          s_done = 1'b1;
          if (!cur_flip) begin
            dir_status = valid_set[chk_idx];
            chk_idx++;
            if (chk_idx == ndirs) last_resp = 1;
          end
        end
      end
      if (s_start) begin
        obs_q.push_back({s_ld, s_flip, s_step});
        cnt = 3; cur_flip = s_flip;
      end
    end
    enable = 1'b0; s_done = 1'b0; dir_status = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({a_ld_data, a_ld_e, a_step, a_ld, a_start, a_flip, a_mask, a_busy, a_mv, a_wr, a_done} !== 25'd0) begin
      errors++; $display("FAIL reset_a outputs got %h want 0",
        {a_ld_data, a_ld_e, a_step, a_ld, a_start, a_flip, a_mask, a_busy, a_mv, a_wr, a_done});
    end
    checks++;
    if ({b_ld_data, b_ld_e, b_step, b_ld, b_start, b_flip, b_mask, b_busy, b_mv, b_wr, b_done} !== 21'd0) begin
      errors++; $display("FAIL reset_b outputs got %h want 0",
        {b_ld_data, b_ld_e, b_step, b_ld, b_start, b_flip, b_mask, b_busy, b_mv, b_wr, b_done});
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_all_invalid;
    sel_b = 1'b0;
    // stray s_done while idle
    @(negedge clock); s_done = 1'b1; dir_status = 1'b1;
    @(negedge clock); s_done = 1'b0; dir_status = 1'b0;
    checks++;
    if (a_busy !== 1'b0) begin errors++; $display("FAIL stray_idle_busy got %b want 0", a_busy); end
    checks++;
    if (a_mask !== 8'h00) begin errors++; $display("FAIL stray_idle_mask got %h want 00", a_mask); end
    push_checks(8);
    run_seq(8'h00, 8, 1'b0, 1'b1, 1'b0);
    checks++;
    if (!done_seen) begin errors++; $display("FAIL all_invalid_done got 0 want 1"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL all_invalid_scan got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL all_invalid_scan got %h want %h", o, e); end end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL all_invalid_extra got %0d want 0", obs_q.size()); end
    checks++;
    if ({obs_mv, obs_wr, obs_mask} !== 10'd0) begin errors++; $display("FAIL all_invalid_final got %h want 000", {obs_mv, obs_wr, obs_mask}); end
    checks++;
    if (ld_pulses != 1) begin errors++; $display("FAIL all_invalid_load got %0d want 1", ld_pulses); end
  endtask

  task automatic test_two_dir;
    sel_b = 1'b0;
    push_checks(8); push_flip(-1); push_flip(11);
    run_seq(8'b1000_0100, 8, 1'b0, 1'b0, 1'b0);
    checks++;
    if (!done_seen) begin errors++; $display("FAIL two_dir_done got 0 want 1"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL two_dir_scan got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL two_dir_scan got %h want %h", o, e); end end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL two_dir_extra got %0d want 0", obs_q.size()); end
    checks++;
    if ({obs_mv, obs_wr, obs_mask} !== {2'b11, 8'b1000_0100}) begin
      errors++; $display("FAIL two_dir_final got %h want 384", {obs_mv, obs_wr, obs_mask});
    end
    @(negedge clock);
    checks++;
    if ({a_done, a_busy, a_mask} !== {2'b00, 8'b1000_0100}) begin
      errors++; $display("FAIL two_dir_after got %h want 084", {a_done, a_busy, a_mask});
    end
  endtask

  task automatic test_four_dirs;
    sel_b = 1'b1;
    push_checks(4);
    for (int i = 0; i < 4; i++) push_flip(chk_steps[i]);
    run_seq(8'h0F, 4, 1'b0, 1'b0, 1'b0);
    checks++;
    if (!done_seen) begin errors++; $display("FAIL four_dirs_done got 0 want 1"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL four_dirs_scan got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL four_dirs_scan got %h want %h", o, e); end end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL four_dirs_extra got %0d want 0", obs_q.size()); end
    checks++;
    if ({obs_mv, obs_wr, obs_mask} !== {2'b11, 8'h0F}) begin
      errors++; $display("FAIL four_dirs_final got %h want 30f", {obs_mv, obs_wr, obs_mask});
    end
    sel_b = 1'b0;
  endtask

  task automatic test_enable_busy;
    sel_b = 1'b0;
    push_checks(8); push_flip(10); push_flip(-9);
    run_seq(8'b0010_0010, 8, 1'b1, 1'b0, 1'b0);
    checks++;
    if (!done_seen) begin errors++; $display("FAIL en_busy_done got 0 want 1"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL en_busy_scan got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL en_busy_scan got %h want %h", o, e); end end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL en_busy_extra got %0d want 0", obs_q.size()); end
    checks++;
    if (ld_pulses != 1) begin errors++; $display("FAIL en_busy_load got %0d want 1", ld_pulses); end
    checks++;
    if ({obs_mv, obs_mask} !== {1'b1, 8'b0010_0010}) begin
      errors++; $display("FAIL en_busy_final got %h want 122", {obs_mv, obs_mask});
    end
  endtask

  task automatic test_reset_mid;
    sel_b = 1'b0;
    push_checks(8); push_flip(-10);
    run_seq(8'b0000_0001, 8, 1'b0, 1'b0, 1'b1);
    checks++;
    if (!rst_hit) begin errors++; $display("FAIL rst_mid_reached got 0 want 1"); end
    checks++;
    if (rst_outs !== 25'd0) begin errors++; $display("FAIL rst_mid_outputs got %h want 0", rst_outs); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL rst_mid_scan got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL rst_mid_scan got %h want %h", o, e); end end
    end
    @(negedge clock);
    reset = 1'b1;
    push_checks(8); push_flip(9);
    run_seq(8'b0100_0000, 8, 1'b0, 1'b0, 1'b0);
    checks++;
    if (!done_seen) begin errors++; $display("FAIL rst_after_done got 0 want 1"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL rst_after_scan got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL rst_after_scan got %h want %h", o, e); end end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL rst_after_extra got %0d want 0", obs_q.size()); end
    checks++;
    if ({obs_mv, obs_wr, obs_mask} !== {2'b11, 8'b0100_0000}) begin
      errors++; $display("FAIL rst_after_final got %h want 340", {obs_mv, obs_wr, obs_mask});
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; s_done = 1'b0; dir_status = 1'b0; sel_b = 1'b0;
    test_reset();
    test_all_invalid();
    test_two_dir();
    test_four_dirs();
    test_enable_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
